// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder output stage, the frame accumulator
// and the downstream checker/logger. The slave side is the accumulator.
interface sum_accumulator_if #(
    parameter int IN_W      = 14,
    parameter int ACC_W     = 18,
    parameter int FRAME_LEN = 16
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    // Input side: one adder sum per valid/ready handshake
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_sum;

    // Output side: frame total, sample count and sticky overflow
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums FRAME_LEN unsigned adder results (or fewer when
// flushed) into a saturating ACC_W register and presents the total, sample
// count and sticky overflow flag until the consumer takes them.
module sum_accumulator #(
    parameter int IN_W      = 14,
    parameter int ACC_W     = 18,
    parameter int FRAME_LEN = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_flush,
    sum_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               r_ovf;
    logic               w_ovf_next;
    logic               r_in_ready;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_release;
    logic [ACC_W:0]     w_sum;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_frame_full;

    // Handshake qualifiers and the one-bit-wider unsigned sum used for saturation
    always_comb begin
        w_accept     = bus.in_valid && r_in_ready && !i_clear;
        w_release    = r_out_valid && bus.out_ready;
        w_sum        = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_sum};
        w_count_inc  = r_count + 1'b1;
        w_frame_full = (w_count_inc == CNT_W'(FRAME_LEN));
    end

    // Next-state and next-datapath logic; clear overrides everything
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_count_next = r_count;
        w_ovf_next   = r_ovf;

        if (i_clear) begin
            w_state_next = IDLE;
            w_acc_next   = '0;
            w_count_next = '0;
            w_ovf_next   = 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        // A sample arriving with flush is folded in before closing
                        w_acc_next   = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
                        w_ovf_next   = r_ovf | w_sum[ACC_W];
                        w_count_next = w_count_inc;
                        w_state_next = (w_frame_full || i_flush) ? HOLD : ACCUM;
                    end else if (i_flush && (r_state == ACCUM)) begin
                        // Flush on an empty frame (IDLE) has nothing to report
                        w_state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (w_release) begin
                        w_state_next = IDLE;
                        w_acc_next   = '0;
                        w_count_next = '0;
                        w_ovf_next   = 1'b0;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_acc_next   = '0;
                    w_count_next = '0;
                    w_ovf_next   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers; handshake flags derive from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_count     <= w_count_next;
            r_ovf       <= w_ovf_next;
            r_in_ready  <= (w_state_next != HOLD);
            r_out_valid <= (w_state_next == HOLD);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_acc   = r_acc;
    assign bus.out_count = r_count;
    assign bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator. Two instances share the stimulus: the
// default 18-bit accumulator and a 16-bit one used to exercise saturation.
module tb_sum_accumulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        flush;
    logic        in_valid;
    logic [13:0] in_sum;
    logic        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    sum_accumulator_if #(.IN_W(14), .ACC_W(18), .FRAME_LEN(16)) bus_a ();
    sum_accumulator_if #(.IN_W(14), .ACC_W(16), .FRAME_LEN(16)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_sum    = in_sum;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_sum    = in_sum;
    assign bus_b.out_ready = out_ready;

    sum_accumulator #(.IN_W(14), .ACC_W(18), .FRAME_LEN(16)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (clear),
        .i_flush (flush),
        .bus     (bus_a)
    );

    sum_accumulator #(.IN_W(14), .ACC_W(16), .FRAME_LEN(16)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (clear),
        .i_flush (flush),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Take the presented frame (one-cycle out_ready pulse) and log it
    task automatic take_frame();
        $display("frame: acc=%0d count=%0d ovf=%0d", bus_a.out_acc, bus_a.out_count, bus_a.out_ovf);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Present one sample for a single cycle
    task automatic send(input logic [13:0] v, input logic fl);
        in_valid = 1'b1;
        in_sum   = v;
        flush    = fl;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;

        // ---- reset / idle ----
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready",  32'(bus_a.in_ready), 0);
        check_eq("rst_out_valid", 32'(bus_a.out_valid), 0);
        check_eq("rst_acc",       32'(bus_a.out_acc), 0);
        check_eq("rst_count",     32'(bus_a.out_count), 0);
        check_eq("rst_ovf",       32'(bus_a.out_ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_in_ready", 32'(bus_a.in_ready), 1);
        repeat (2) @(negedge clk);
        check_eq("idle_out_valid", 32'(bus_a.out_valid), 0);

        // ---- full frame, back-to-back ----
        in_sum = 14'd16382;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 14) begin
                check_eq("full_valid_at15", 32'(bus_a.out_valid), 0);
                check_eq("full_count_at15", 32'(bus_a.out_count), 15);
            end
        end
        in_valid = 1'b0;
        check_eq("full_out_valid", 32'(bus_a.out_valid), 1);
        check_eq("full_acc",       32'(bus_a.out_acc), 262112);
        check_eq("full_count",     32'(bus_a.out_count), 16);
        check_eq("full_ovf",       32'(bus_a.out_ovf), 0);
        check_eq("full_in_ready",  32'(bus_a.in_ready), 0);

        // ---- backpressure: result held, input ignored ----
        in_valid = 1'b1;
        in_sum   = 14'd100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("hold_acc",      32'(bus_a.out_acc), 262112);
            check_eq("hold_count",    32'(bus_a.out_count), 16);
            check_eq("hold_valid",    32'(bus_a.out_valid), 1);
            check_eq("hold_in_ready", 32'(bus_a.in_ready), 0);
        end
        in_valid = 1'b0;
        take_frame();
        check_eq("rel_out_valid", 32'(bus_a.out_valid), 0);
        check_eq("rel_in_ready",  32'(bus_a.in_ready), 1);
        check_eq("rel_acc",       32'(bus_a.out_acc), 0);
        check_eq("rel_count",     32'(bus_a.out_count), 0);

        // ---- saturation on the 16-bit instance ----
        in_sum = 14'd16383;
        in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 4) begin
                check_eq("sat_acc_4", 32'(bus_b.out_acc), 65532);
                check_eq("sat_ovf_4", 32'(bus_b.out_ovf), 0);
            end
            if (i == 5) begin
                check_eq("sat_acc_5", 32'(bus_b.out_acc), 65535);
                check_eq("sat_ovf_5", 32'(bus_b.out_ovf), 1);
            end
        end
        in_valid = 1'b0;
        check_eq("sat_end_valid", 32'(bus_b.out_valid), 1);
        check_eq("sat_end_acc",   32'(bus_b.out_acc), 65535);
        check_eq("sat_end_ovf",   32'(bus_b.out_ovf), 1);
        check_eq("sat_end_count", 32'(bus_b.out_count), 16);
        check_eq("nosat_acc",     32'(bus_a.out_acc), 262128);
        check_eq("nosat_ovf",     32'(bus_a.out_ovf), 0);
        take_frame();
        check_eq("sat_rel_ovf",   32'(bus_b.out_ovf), 0);
        check_eq("sat_rel_acc",   32'(bus_b.out_acc), 0);

        // ---- flush ----
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("idle_flush_valid", 32'(bus_a.out_valid), 0);
        check_eq("idle_flush_ready", 32'(bus_a.in_ready), 1);
        send(14'd3, 1'b0);
        send(14'd5, 1'b0);
        send(14'd7, 1'b0);
        send(14'd9, 1'b1);
        check_eq("flush_valid", 32'(bus_a.out_valid), 1);
        check_eq("flush_acc",   32'(bus_a.out_acc), 24);
        check_eq("flush_count", 32'(bus_a.out_count), 4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("hold_flush_acc", 32'(bus_a.out_acc), 24);
        take_frame();
        send(14'd11, 1'b1);
        check_eq("idle_acc_flush_valid", 32'(bus_a.out_valid), 1);
        check_eq("idle_acc_flush_acc",   32'(bus_a.out_acc), 11);
        check_eq("idle_acc_flush_count", 32'(bus_a.out_count), 1);
        take_frame();

        // ---- clear mid-frame ----
        for (int i = 1; i <= 5; i++) send(14'(i), 1'b0);
        check_eq("pre_clear_acc", 32'(bus_a.out_acc), 15);
        clear = 1'b1;
        in_valid = 1'b1;
        in_sum = 14'd1000;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        check_eq("clear_acc",      32'(bus_a.out_acc), 0);
        check_eq("clear_count",    32'(bus_a.out_count), 0);
        check_eq("clear_in_ready", 32'(bus_a.in_ready), 1);
        in_sum = 14'd2;
        in_valid = 1'b1;
        repeat (16) @(negedge clk);
        in_valid = 1'b0;
        check_eq("post_clear_valid", 32'(bus_a.out_valid), 1);
        check_eq("post_clear_acc",   32'(bus_a.out_acc), 32);
        check_eq("post_clear_count", 32'(bus_a.out_count), 16);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_eq("hold_clear_valid", 32'(bus_a.out_valid), 0);
        check_eq("hold_clear_count", 32'(bus_a.out_count), 0);
        check_eq("hold_clear_ready", 32'(bus_a.in_ready), 1);

        // ---- asynchronous reset mid-frame ----
        for (int i = 0; i < 3; i++) send(14'd50, 1'b0);
        check_eq("pre_rst_acc", 32'(bus_a.out_acc), 150);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_acc",   32'(bus_a.out_acc), 0);
        check_eq("async_rst_count", 32'(bus_a.out_count), 0);
        check_eq("async_rst_ready", 32'(bus_a.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(bus_a.in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
